// File: rtl/pulse_burst_detector_pkg.sv
// rtl/pulse_burst_detector_pkg.sv - shared FSM encoding and default parameters for pulse_burst_detector
package pulse_burst_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_CNT_W      = 4;
  localparam int DEF_GAP_CYCLES = 4;
  localparam int DEF_MAX_PULSES = 15;

endpackage

// File: rtl/pulse_burst_detector_pulse_sync.sv
// rtl/pulse_burst_detector_pulse_sync.sv - input sampler (PULSE_BURST_DETECTOR_SYNC_EN adds a 2-flop synchronizer)
module pulse_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic sig_q;

`ifdef PULSE_BURST_DETECTOR_SYNC_EN
  logic meta_q;
  logic stage_q;

  // Two-flop synchronizer ahead of the sample register for asynchronous sources.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b0;
      stage_q <= 1'b0;
      sig_q   <= 1'b0;
    end else begin
      meta_q  <= d_i;
      stage_q <= meta_q;
      sig_q   <= stage_q;
    end
  end
`else
  // Single sample register; the source is assumed synchronous to clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= d_i;
    end
  end
`endif

  assign q_o = sig_q;

endmodule

// File: rtl/pulse_burst_detector.sv
// rtl/pulse_burst_detector.sv - counts high pulses per burst and reports the count once the burst closes (PULSE_BURST_DETECTOR_SYNC_EN selects the synchronizing sampler)
module pulse_burst_detector
  import pulse_burst_detector_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MAX_PULSES = DEF_MAX_PULSES
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             signal_in,
  output logic [CNT_W-1:0] burst_count,
  output logic             burst_valid,
  output logic             burst_ovf,
  output logic             busy
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  logic             sig_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_inc;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             bovf_q, bovf_d;
  logic             busy_q;

  pulse_sync u_sync (
    .clk_i  (clock),
    .rst_ni (resetn),
    .d_i    (signal_in),
    .q_o    (sig_q)
  );

  // Running count of consecutive low samples: the first low after HIGH counts as one.
  assign gap_inc = (state_q == ST_HIGH) ? GAP_W'(1) : gap_q + GAP_W'(1);

  // Next-state logic: count pulses, saturate at MAX_PULSES, close the burst on the
  // GAP_CYCLES-th consecutive low sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    bovf_d  = bovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sig_q) begin
          cnt_d   = CNT_W'(1);
          ovf_d   = 1'b0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH, ST_GAP: begin
        if (sig_q) begin
          if (state_q == ST_GAP) begin
            if (cnt_q == CNT_W'(MAX_PULSES)) begin
              ovf_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          state_d = ST_HIGH;
        end else if (gap_inc == GAP_W'(GAP_CYCLES)) begin
          count_d = cnt_q;
          bovf_d  = ovf_q;
          valid_d = 1'b1;
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d   = gap_inc;
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and report registers; busy tracks the next state so it drops with the strobe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      bovf_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      valid_q <= valid_d;
      bovf_q  <= bovf_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign burst_count = count_q;
  assign burst_valid = valid_q;
  assign burst_ovf   = bovf_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pulse_burst_detector.sv
// tb/tb_pulse_burst_detector.sv - scoreboard bench for pulse_burst_detector (default build)
module tb_pulse_burst_detector;

  localparam int CNT_W      = 4;
  localparam int GAP_CYCLES = 4;
  localparam int MAX_PULSES = 15;

  logic             clock;
  logic             resetn;
  logic             signal_in;
  logic [CNT_W-1:0] burst_count;
  logic             burst_valid;
  logic             burst_ovf;
  logic             busy;

  typedef struct {
    int cnt;
    int ovf;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;
  int   cyc;
  int   last_hi;

  pulse_burst_detector #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_PULSES (MAX_PULSES)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .signal_in   (signal_in),
    .burst_count (burst_count),
    .burst_valid (burst_valid),
    .burst_ovf   (burst_ovf),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec = n_vec + 1;
    if (obs != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // One value per cycle, applied at the falling edge; records the edge that samples a high.
  task automatic drive(input logic v);
    @(negedge clock);
    signal_in = v;
    if (v) last_hi = cyc + 1;
  endtask

  task automatic expect_report(input int n);
    exp_t e;
    e.cnt    = (n > MAX_PULSES) ? MAX_PULSES : n;
    e.ovf    = (n > MAX_PULSES) ? 1 : 0;
    e.at_cyc = last_hi + GAP_CYCLES + 1;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      drive(1'b0);
      budget = budget - 1;
    end
    check_eq(tag, sb.size(), 0);
  endtask

  // n pulses of one high sample each, separated by `lows` low samples, then a closing gap.
  task automatic send_burst(input int n, input int lows, input string tag);
    for (int p = 0; p < n; p++) begin
      drive(1'b1);
      if (p < n - 1) begin
        for (int k = 0; k < lows; k++) drive(1'b0);
      end
    end
    expect_report(n);
    for (int k = 0; k < GAP_CYCLES + 3; k++) drive(1'b0);
    drain(tag);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expected report.
  always @(negedge clock) begin
    if (burst_valid) begin
      check_eq("valid_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check_eq("burst_count", int'(burst_count), e.cnt);
        check_eq("burst_ovf", int'(burst_ovf), e.ovf);
        check_eq("report_cycle", cyc, e.at_cyc);
        check_eq("busy_at_report", int'(busy), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    last_hi   = 0;
    resetn    = 1'b0;
    signal_in = 1'b0;

    // Reset then idle.
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_count", int'(burst_count), 0);
    check_eq("rst_valid", int'(burst_valid), 0);
    check_eq("rst_ovf", int'(burst_ovf), 0);
    check_eq("rst_busy", int'(busy), 0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) drive(1'b0);
    check_eq("idle_busy", int'(busy), 0);
    check_eq("idle_count", int'(burst_count), 0);

    // Three 1-high/1-low pulses.
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    check_eq("busy_mid_burst", int'(busy), 1);
    drive(1'b0);
    drive(1'b1);
    expect_report(3);
    for (int k = 0; k < GAP_CYCLES + 3; k++) drive(1'b0);
    drain("drain_three");

    // Gaps of GAP_CYCLES-1 lows keep the burst open.
    send_burst(5, GAP_CYCLES - 1, "drain_gap3");

    // Saturation, then a normal burst clears overflow.
    send_burst(17, 1, "drain_sat");
    send_burst(2, 1, "drain_after_sat");

    // Reset mid-burst aborts without a report.
    drive(1'b1);
    drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_valid", int'(burst_valid), 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int k = 0; k < 12; k++) drive(1'b0);
    check_eq("abort_sb_empty", sb.size(), 0);
    send_burst(1, 1, "drain_after_abort");

    // Stuck-high input: busy throughout, single pulse reported after it falls.
    for (int i = 0; i < 50; i++) begin
      drive(1'b1);
      if (i >= 2) check_eq("stuck_busy", int'(busy), 1);
    end
    check_eq("stuck_no_report", sb.size(), 0);
    expect_report(1);
    for (int k = 0; k < GAP_CYCLES + 3; k++) drive(1'b0);
    drain("drain_stuck");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
